wb_hazard_scoreboard: RTL and testbench

- In-order issue/retire scoreboard that sequences the D->E stage-bus handshake for the 5-stage NPC pipeline.
- Records the destination register of every instruction handed to the E stage.
- Removes that record when the instruction commits at W.
- Stalls decode on RAW hazards, on full occupancy, and for serializing instructions (CSR/ecall/fence).
- Generates the pipeline flush pulse when a W-stage commit redirects the PC.

---
 rtl/wb_hazard_scoreboard_pkg.sv | 20 ++
 rtl/wb_hazard_scoreboard_sb_tag_fifo.sv | 89 ++++++++
 rtl/wb_hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_wb_hazard_scoreboard.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_hazard_scoreboard_pkg.sv
// Shared types and constants for the issue/retire hazard scoreboard.
package wb_hazard_scoreboard_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_TAG_W = 6;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_SOLO  = 2'd2,
        SB_FLUSH = 2'd3
    } sb_state_e;

    // One in-flight destination record: {rd, wen}
    typedef struct packed {
        logic [4:0] rd;
        logic       wen;
    } sb_tag_t;

endpackage

// File: rtl/wb_hazard_scoreboard_sb_tag_fifo.sv
// In-order tag FIFO holding {rd, wen} for every issued, uncommitted instruction.
// All slots are exposed with per-slot valid bits so the top can compare in parallel.
module wb_hazard_scoreboard_sb_tag_fifo
    import wb_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PTR_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      push,
    input  sb_tag_t                   push_tag,
    input  logic                      pop,
    output logic [PTR_W:0]            count,
    output sb_tag_t                   head_tag,
    output logic [DEPTH*SB_TAG_W-1:0] entries,
    output logic [DEPTH-1:0]          entry_vld
);

    sb_tag_t          mem_q [DEPTH];
    sb_tag_t          mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;

    // Next-state: clear wins; otherwise pop at head and push at tail independently
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            vld_d   = '0;
        end else begin
            if (pop) begin
                vld_d[head_q] = 1'b0;
                head_d        = head_q + PTR_W'(1);
            end
            if (push) begin
                mem_d[tail_q] = push_tag;
                vld_d[tail_q] = 1'b1;
                tail_d        = tail_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Flatten storage for the parallel hazard comparators
    always_comb begin
        entries = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*SB_TAG_W +: SB_TAG_W] = mem_q[i];
        end
    end

    assign count     = count_q;
    assign head_tag  = mem_q[head_q];
    assign entry_vld = vld_q;

endmodule

// File: rtl/wb_hazard_scoreboard.sv
// In-order issue/retire scoreboard: gates the D->E handshake on RAW hazards,
// occupancy and serializing instructions, and raises flush after a redirecting commit.
module wb_hazard_scoreboard
    import wb_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_used,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    input  logic             id_serial,
    output logic             id_ready,
    input  logic             ex_ready,
    output logic             ex_valid,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_rd_wen,
    input  logic             wb_redirect,
    output logic             flush,
    output logic [PTR_W:0]   inflight,
    output logic             sb_empty,
    output logic             sb_full,
    output logic             tag_err
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    sb_state_e                 state_q, state_d;
    logic                      tag_err_q, tag_err_d;
    logic [PTR_W:0]            count;
    sb_tag_t                   head_tag;
    logic [DEPTH*SB_TAG_W-1:0] entries;
    logic [DEPTH-1:0]          entry_vld;
    logic                      raw_hit, block, issue, redirect, fifo_pop;

    assign redirect = wb_valid & wb_redirect;
    assign sb_empty = (count == '0);
    assign sb_full  = (count == FULL_CNT);
    assign inflight = count;
    // Redirect clears the FIFO, so a pop in the same cycle is moot
    assign fifo_pop = wb_valid & ~sb_empty & ~redirect;

    wb_hazard_scoreboard_sb_tag_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (redirect),
        .push      (issue),
        .push_tag  ({id_rd, id_rd_wen}),
        .pop       (fifo_pop),
        .count     (count),
        .head_tag  (head_tag),
        .entries   (entries),
        .entry_vld (entry_vld)
    );

    // RAW compare against every live writer; x0 sources never match
    always_comb begin
        sb_tag_t tag;
        tag     = '0;
        raw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tag = entries[i*SB_TAG_W +: SB_TAG_W];
            if (entry_vld[i] && tag.wen) begin
                if (id_rs1_used && (id_rs1 != 5'd0) && (tag.rd == id_rs1)) raw_hit = 1'b1;
                if (id_rs2_used && (id_rs2 != 5'd0) && (tag.rd == id_rs2)) raw_hit = 1'b1;
            end
        end
    end

    // Issue gating; the retiring entry still blocks this cycle (no write-through)
    always_comb begin
        block = raw_hit | sb_full | (state_q != SB_RUN) | (id_serial & ~sb_empty) | redirect;
        ex_valid = id_valid & ~block;
        id_ready = ex_ready & ~block;
        issue    = id_valid & id_ready;
    end

    // Sequencing FSM next state; redirect overrides everything
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = SB_FLUSH;
        end else begin
            unique case (state_q)
                SB_RUN: begin
                    if (id_valid && id_serial) begin
                        if (!sb_empty) state_d = SB_DRAIN;
                        else if (issue) state_d = SB_SOLO;
                    end
                end
                SB_DRAIN: begin
                    // Leave as soon as the last older instruction retires
                    if (sb_empty || ((count == (PTR_W+1)'(1)) && fifo_pop)) state_d = SB_RUN;
                end
                SB_SOLO: begin
                    if (wb_valid) state_d = SB_RUN;
                end
                SB_FLUSH: state_d = SB_RUN;
                default:  state_d = SB_RUN;
            endcase
        end
    end

    // Sticky protocol error: commit with nothing in flight or with the wrong tag
    always_comb begin
        tag_err_d = tag_err_q;
        if (wb_valid && (sb_empty || ({wb_rd, wb_rd_wen} != head_tag))) tag_err_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SB_RUN;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign flush   = (state_q == SB_FLUSH);
    assign tag_err = tag_err_q;

endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_wb_hazard_scoreboard;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk, rst_n;
    logic             id_valid, id_rs1_used, id_rs2_used, id_rd_wen, id_serial;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_ready, ex_ready, ex_valid;
    logic             wb_valid, wb_rd_wen, wb_redirect;
    logic [4:0]       wb_rd;
    logic             flush, sb_empty, sb_full, tag_err;
    logic [PTR_W:0]   inflight;

    wb_hazard_scoreboard #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs1_used (id_rs1_used),
        .id_rs2      (id_rs2),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_wen   (id_rd_wen),
        .id_serial   (id_serial),
        .id_ready    (id_ready),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_rd_wen   (wb_rd_wen),
        .wb_redirect (wb_redirect),
        .flush       (flush),
        .inflight    (inflight),
        .sb_empty    (sb_empty),
        .sb_full     (sb_full),
        .tag_err     (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model: in-flight {rd,wen} list, mode flags and sticky error
    logic [5:0] mq[$];
    bit m_drain, m_solo, m_flush, m_err;

    function automatic bit m_block();
        bit hit;
        hit = 0;
        foreach (mq[i]) begin
            if (mq[i][0]) begin
                if (id_rs1_used && id_rs1 != 0 && mq[i][5:1] == id_rs1) hit = 1;
                if (id_rs2_used && id_rs2 != 0 && mq[i][5:1] == id_rs2) hit = 1;
            end
        end
        return hit || (mq.size() == DEPTH) || m_drain || m_solo || m_flush
            || (id_serial && mq.size() != 0) || (wb_valid && wb_redirect);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_drain = 0;
        m_solo  = 0;
        m_flush = 0;
        m_err   = 0;
    endtask

    task automatic m_step();
        bit blk, empty0, issue, was_drain, was_solo, was_flush;
        blk       = m_block();
        empty0    = (mq.size() == 0);
        issue     = id_valid && ex_ready && !blk;
        was_drain = m_drain;
        was_solo  = m_solo;
        was_flush = m_flush;
        if (wb_valid && (empty0 || mq[0] != {wb_rd, wb_rd_wen})) m_err = 1;
        if (wb_valid && wb_redirect) begin
            mq.delete();
            m_flush = 1;
            m_drain = 0;
            m_solo  = 0;
        end else begin
            if (wb_valid && !empty0) void'(mq.pop_front());
            if (issue) mq.push_back({id_rd, id_rd_wen});
            if (was_flush) m_flush = 0;
            else if (was_drain) begin
                if (mq.size() == 0) m_drain = 0;
            end else if (was_solo) begin
                if (wb_valid) m_solo = 0;
            end else if (id_valid && id_serial) begin
                if (!empty0) m_drain = 1;
                else if (issue) m_solo = 1;
            end
        end
    endtask

    always @(negedge rst_n) m_reset();

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ex_valid", ex_valid, id_valid && !m_block());
            check("id_ready", id_ready, ex_ready && !m_block());
            check("flush", flush, m_flush);
            check("inflight", inflight, mq.size());
            check("sb_empty", sb_empty, mq.size() == 0);
            check("sb_full", sb_full, mq.size() == DEPTH);
            check("tag_err", tag_err, m_err);
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_wen = 0; id_serial = 0; ex_ready = 1;
        wb_valid = 0; wb_rd = 0; wb_rd_wen = 0; wb_redirect = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic wen, input logic [4:0] rs1,
                          input logic u1, input logic ser);
        id_valid = 1; id_rd = rd; id_rd_wen = wen; id_rs1 = rs1; id_rs1_used = u1;
        id_rs2 = 0; id_rs2_used = 0; id_serial = ser;
    endtask

    task automatic commit_head(input logic redir);
        wb_valid = 1;
        {wb_rd, wb_rd_wen} = mq[0];
        wb_redirect = redir;
    endtask

    task automatic drain_all();
        id_valid = 0;
        for (int n = 0; n < 16 && mq.size() > 0; n++) begin
            commit_head(0);
            cyc();
        end
        wb_valid = 0;
        settle();
        check("drained", sb_empty, 1);
    endtask

    task automatic issue_n(input int n, input int base_rd);
        for (int k = 0; k < n; k++) begin
            set_id(5'(base_rd + k), 1, 0, 0, 0);
            cyc();
        end
        id_valid = 0;
    endtask

    initial begin
        idle();
        ex_ready = 0;
        rst_n = 0;
        #2;
        check("rst_inflight", inflight, 0);
        check("rst_flush", flush, 0);
        check("rst_tag_err", tag_err, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_id_ready", id_ready, 0);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        ex_ready = 1;
        cyc();

        // RAW stall and release the cycle after commit
        set_id(5, 1, 0, 0, 0);
        settle();
        check("raw_first", ex_valid, 1);
        cyc();
        set_id(6, 1, 5, 1, 0);
        settle();
        check("raw_block", ex_valid, 0);
        cyc();
        cyc();
        commit_head(0);
        settle();
        check("raw_retiring_blocks", ex_valid, 0);
        cyc();
        wb_valid = 0;
        settle();
        check("raw_release", ex_valid, 1);
        cyc();
        set_id(0, 1, 0, 0, 0);
        cyc();
        set_id(1, 0, 0, 1, 0);
        id_rs2_used = 1;
        settle();
        check("x0_no_block", ex_valid, 1);
        cyc();
        drain_all();

        // Full occupancy
        issue_n(4, 1);
        set_id(9, 1, 0, 0, 0);
        settle();
        check("full_flag", sb_full, 1);
        check("full_count", inflight, 4);
        check("full_id_ready", id_ready, 0);
        commit_head(0);
        settle();
        check("full_commit_block", ex_valid, 0);
        cyc();
        wb_valid = 0;
        settle();
        check("after_pop_count", inflight, 3);
        check("pending_issues", ex_valid, 1);
        cyc();
        settle();
        check("refill_count", inflight, 4);
        id_valid = 0;
        commit_head(0);
        cyc();
        set_id(10, 1, 0, 0, 0);
        commit_head(0);
        cyc();
        wb_valid = 0;
        id_valid = 0;
        settle();
        check("push_pop_count", inflight, 3);
        drain_all();

        // Serializing instruction: drain, issue alone, block until it commits
        issue_n(2, 10);
        set_id(12, 1, 0, 0, 1);
        settle();
        check("serial_wait", ex_valid, 0);
        cyc();
        commit_head(0);
        settle();
        check("drain_block", ex_valid, 0);
        cyc();
        commit_head(0);
        cyc();
        wb_valid = 0;
        settle();
        check("serial_issue", ex_valid, 1);
        check("serial_empty", inflight, 0);
        cyc();
        set_id(13, 1, 0, 0, 0);
        settle();
        check("solo_block", ex_valid, 0);
        cyc();
        commit_head(0);
        settle();
        check("solo_commit_block", ex_valid, 0);
        cyc();
        wb_valid = 0;
        settle();
        check("after_solo", ex_valid, 1);
        cyc();
        drain_all();

        // Redirect flush
        issue_n(3, 1);
        set_id(4, 1, 0, 0, 0);
        commit_head(1);
        settle();
        check("redir_no_issue", ex_valid, 0);
        cyc();
        wb_valid = 0;
        wb_redirect = 0;
        settle();
        check("flush_high", flush, 1);
        check("flush_inflight", inflight, 0);
        check("flush_block", ex_valid, 0);
        cyc();
        settle();
        check("flush_low", flush, 0);
        check("post_flush_issue", ex_valid, 1);
        cyc();
        drain_all();

        // Commit while empty
        id_valid = 0;
        wb_valid = 1; wb_rd = 3; wb_rd_wen = 1;
        cyc();
        wb_valid = 0;
        settle();
        check("err_empty", tag_err, 1);
        check("err_inflight", inflight, 0);
        repeat (3) cyc();
        check("err_sticky", tag_err, 1);

        // Async reset in the middle of a drain
        issue_n(3, 1);
        set_id(9, 1, 0, 0, 1);
        cyc();
        #2;
        rst_n = 0;
        #1;
        check("arst_inflight", inflight, 0);
        check("arst_flush", flush, 0);
        check("arst_tag_err", tag_err, 0);
        cyc();
        rst_n = 1;
        settle();
        check("arst_run", ex_valid, 1);
        cyc();
        id_valid = 0;
        commit_head(0);
        cyc();
        wb_valid = 0;

        // Tag mismatch
        set_id(7, 1, 0, 0, 0);
        cyc();
        id_valid = 0;
        wb_valid = 1; wb_rd = 8; wb_rd_wen = 1;
        cyc();
        wb_valid = 0;
        settle();
        check("err_mismatch", tag_err, 1);

        // Random traffic with periodic async resets
        for (int c = 0; c < 3000; c++) begin
            idle();
            id_valid    = ($urandom_range(99) < 70);
            id_rs1      = 5'($urandom_range(7));
            id_rs1_used = 1'($urandom_range(1));
            id_rs2      = 5'($urandom_range(7));
            id_rs2_used = 1'($urandom_range(1));
            id_rd       = 5'($urandom_range(7));
            id_rd_wen   = 1'($urandom_range(1));
            id_serial   = ($urandom_range(99) < 5);
            ex_ready    = ($urandom_range(99) < 80);
            if (mq.size() > 0 && $urandom_range(99) < 40) begin
                commit_head($urandom_range(99) < 6);
                if ($urandom_range(99) < 2) wb_rd = wb_rd ^ 5'd1;
            end else if ($urandom_range(999) < 5) begin
                wb_valid = 1;
                wb_rd = 5'($urandom_range(7));
                wb_rd_wen = 1;
            end
            if (c % 600 == 599) begin
                #2;
                rst_n = 0;
                cyc();
                rst_n = 1;
            end else begin
                cyc();
            end
        end

        idle();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
